// File: rtl/mips_harvard_mem_responder.sv
// Memory-side responder for the Harvard MIPS core.
// Serves instruction fetches from a boot ROM, loads/stores to a data RAM,
// and a three-word MMIO block (CYCLE, EXIT, STATUS). Tracks the run state,
// latches the program exit code and records the first illegal access.
// A preload port fills ROM/RAM while the core is idle.
module mips_harvard_mem_responder #(
    parameter logic [31:0] ROM_BASE  = 32'hBFC0_0000,
    parameter int          ROM_WORDS = 1024,
    parameter logic [31:0] RAM_BASE  = 32'h0000_1000,
    parameter int          RAM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = 32'h0000_0F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    input  logic        cpu_active,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        done,
    output logic [31:0] exit_code,
    output logic [31:0] cycle_count,
    output logic        access_error,
    output logic [31:0] err_address
);

    localparam int          ROM_AW     = $clog2(ROM_WORDS);
    localparam int          RAM_AW     = $clog2(RAM_WORDS);
    localparam logic [31:0] ROM_BYTES  = 32'(ROM_WORDS) << 2;
    localparam logic [31:0] RAM_BYTES  = 32'(RAM_WORDS) << 2;
    localparam logic [31:0] MMIO_BYTES = 32'd12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    // An address hits a window only when word-aligned and base <= addr < base+bytes.
    // The unsigned subtract wraps addresses below base to huge offsets.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] bytes);
        logic [31:0] offset;
        offset = addr - base;
        return (addr[1:0] == 2'b00) && (offset < bytes);
    endfunction

    state_t      state;
    state_t      state_next;

    logic [31:0] rom [ROM_WORDS];
    logic [31:0] ram [RAM_WORDS];

    // Address decode for the three address sources.
    logic              i_in_rom;
    logic              d_in_rom;
    logic              d_in_ram;
    logic              d_in_mmio;
    logic              l_in_rom;
    logic              l_in_ram;
    logic [ROM_AW-1:0] i_rom_idx;
    logic [ROM_AW-1:0] d_rom_idx;
    logic [RAM_AW-1:0] d_ram_idx;
    logic [ROM_AW-1:0] l_rom_idx;
    logic [RAM_AW-1:0] l_ram_idx;
    logic [1:0]        mmio_sel;

    assign i_in_rom  = in_window(instr_address, ROM_BASE, ROM_BYTES);
    assign d_in_rom  = in_window(data_address, ROM_BASE, ROM_BYTES);
    assign d_in_ram  = in_window(data_address, RAM_BASE, RAM_BYTES);
    assign d_in_mmio = in_window(data_address, MMIO_BASE, MMIO_BYTES);
    assign l_in_rom  = in_window(load_addr, ROM_BASE, ROM_BYTES);
    assign l_in_ram  = in_window(load_addr, RAM_BASE, RAM_BYTES);

    assign i_rom_idx = ROM_AW'((instr_address - ROM_BASE) >> 2);
    assign d_rom_idx = ROM_AW'((data_address - ROM_BASE) >> 2);
    assign d_ram_idx = RAM_AW'((data_address - RAM_BASE) >> 2);
    assign l_rom_idx = ROM_AW'((load_addr - ROM_BASE) >> 2);
    assign l_ram_idx = RAM_AW'((load_addr - RAM_BASE) >> 2);
    assign mmio_sel  = 2'((data_address - MMIO_BASE) >> 2);

    logic        fetch_err;
    logic        data_err;
    logic        run_ok;
    logic        store_ok;
    logic        ram_store;
    logic        exit_store;
    logic        preload_ok;
    logic [31:0] status_word;

    assign run_ok      = (state == S_RUN) && !reset;
    assign store_ok    = run_ok && data_write && !data_read;
    assign ram_store   = store_ok && d_in_ram;
    assign exit_store  = store_ok && d_in_mmio && (mmio_sel == 2'd1);
    assign preload_ok  = (state == S_IDLE) && load_en;
    assign done        = (state == S_HALT);
    assign status_word = {30'b0, access_error, done};

    // Fetch path: ROM word, NOP at the halt address 0, otherwise 0 with an error flag.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        instr_readdata = '0;
        fetch_err      = 1'b0;
        if (i_in_rom) begin
            instr_readdata = rom[i_rom_idx];
        end else if (instr_address != 32'h0) begin
            fetch_err = 1'b1;
        end
    end

    // Load path and data-port error classification (stores to ROM/unmapped/misaligned, dual requests).
    always_comb begin
        data_readdata = '0;
        data_err      = 1'b0;
        if (data_read && data_write) begin
            data_err = 1'b1;
        end else if (data_read) begin
            if (d_in_ram) begin
                data_readdata = ram[d_ram_idx];
            end else if (d_in_rom) begin
                data_readdata = rom[d_rom_idx];
            end else if (d_in_mmio) begin
                case (mmio_sel)
                    2'd0:    data_readdata = cycle_count;
                    2'd1:    data_readdata = exit_code;
                    2'd2:    data_readdata = status_word;
                    default: data_readdata = '0;
                endcase
            end else begin
                data_err = 1'b1;
            end
        end else if (data_write) begin
            if (!(d_in_ram || d_in_mmio)) begin
                data_err = 1'b1;
            end
        end
    end

    // Run-state next-state logic: start on cpu_active, stop on EXIT store or core going inactive.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (cpu_active) state_next = S_RUN;
            S_RUN:   if (exit_store || !cpu_active) state_next = S_HALT;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    // State register with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Status registers: saturating run-cycle counter, exit code, first-error capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            exit_code    <= '0;
            cycle_count  <= '0;
            access_error <= 1'b0;
            err_address  <= '0;
        end else if (state == S_RUN) begin
            if (cycle_count != 32'hFFFF_FFFF) begin
                cycle_count <= cycle_count + 32'd1;
            end
            if (exit_store) begin
                exit_code <= data_writedata;
            end
            if ((data_err || fetch_err) && !access_error) begin
                access_error <= 1'b1;
                err_address  <= data_err ? data_address : instr_address;
            end
        end
    end

    // Boot ROM: written only through the preload port while idle.
    // NOTE: memory arrays are deliberately left out of reset so contents survive a core restart.
    always_ff @(posedge clk) begin
        if (preload_ok && l_in_rom) begin
            rom[l_rom_idx] <= load_data;
        end
    end

    // Data RAM: core stores while running, preload while idle; reads see the old word until the edge.
    always_ff @(posedge clk) begin
        if (ram_store) begin
            ram[d_ram_idx] <= data_writedata;
        end else if (preload_ok && l_in_ram) begin
            ram[l_ram_idx] <= load_data;
        end
    end

endmodule

// File: tb/tb_mips_harvard_mem_responder.sv
// Self-checking bench for mips_harvard_mem_responder.
// A behavioural model (plain arrays and arithmetic on the memory map) predicts
// every output; one compare process checks them on each falling edge, and a
// set of directed runs pins the model with hand-computed literals before a
// randomized phase.
module tb_mips_harvard_mem_responder;

    localparam logic [31:0] ROM_BASE  = 32'hBFC0_0000;
    localparam logic [31:0] RAM_BASE  = 32'h0000_1000;
    localparam logic [31:0] MMIO_BASE = 32'h0000_0F00;
    localparam int          NWORDS    = 1024;

    logic        clk;
    logic        reset;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        cpu_active;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        done;
    logic [31:0] exit_code;
    logic [31:0] cycle_count;
    logic        access_error;
    logic [31:0] err_address;

    mips_harvard_mem_responder dut (
        .clk            (clk),
        .reset          (reset),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata),
        .data_address   (data_address),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata),
        .cpu_active     (cpu_active),
        .load_en        (load_en),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .done           (done),
        .exit_code      (exit_code),
        .cycle_count    (cycle_count),
        .access_error   (access_error),
        .err_address    (err_address)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {REG_NONE, REG_ROM, REG_RAM, REG_MMIO} region_t;

    logic [31:0] m_rom [NWORDS];
    logic [31:0] m_ram [NWORDS];
    int          m_phase = 0;          // 0 idle, 1 running, 2 halted
    logic [31:0] m_exit  = '0;
    logic [31:0] m_cycles = '0;
    bit          m_err   = 1'b0;
    logic [31:0] m_erra  = '0;

    function automatic region_t region(input logic [31:0] a);
        logic [63:0] ua;
        ua = {32'b0, a};
        if (a[1:0] != 2'b00) return REG_NONE;
        if (ua >= {32'b0, ROM_BASE} && ua < {32'b0, ROM_BASE} + 64'(4 * NWORDS)) return REG_ROM;
        if (ua >= {32'b0, RAM_BASE} && ua < {32'b0, RAM_BASE} + 64'(4 * NWORDS)) return REG_RAM;
        if (ua >= {32'b0, MMIO_BASE} && ua < {32'b0, MMIO_BASE} + 64'd12) return REG_MMIO;
        return REG_NONE;
    endfunction

    function automatic int widx(input logic [31:0] a, input logic [31:0] base);
        return int'((a - base) / 4);
    endfunction

    function automatic logic [31:0] exp_fetch(input logic [31:0] a);
        if (region(a) == REG_ROM) return m_rom[widx(a, ROM_BASE)];
        return 32'h0;
    endfunction

    function automatic bit fetch_bad(input logic [31:0] a);
        return (region(a) != REG_ROM) && (a != 32'h0);
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] a, input logic rd, input logic wr);
        if (!rd || wr) return 32'h0;
        case (region(a))
            REG_ROM:  return m_rom[widx(a, ROM_BASE)];
            REG_RAM:  return m_ram[widx(a, RAM_BASE)];
            REG_MMIO: begin
                if (a - MMIO_BASE == 32'd0) return m_cycles;
                if (a - MMIO_BASE == 32'd4) return m_exit;
                return {30'b0, m_err, (m_phase == 2)};
            end
            default:  return 32'h0;
        endcase
    endfunction

    function automatic bit data_bad(input logic [31:0] a, input logic rd, input logic wr);
        region_t r;
        r = region(a);
        if (rd && wr) return 1'b1;
        if (rd) return r == REG_NONE;
        if (wr) return !(r == REG_RAM || r == REG_MMIO);
        return 1'b0;
    endfunction

    task automatic model_preload();
        if (load_en) begin
            if (region(load_addr) == REG_ROM) m_rom[widx(load_addr, ROM_BASE)] = load_data;
            if (region(load_addr) == REG_RAM) m_ram[widx(load_addr, RAM_BASE)] = load_data;
        end
    endtask

    // Model advance on each rising edge, from the inputs held during the past cycle.
    always @(posedge clk) begin : model_step
        bit halt_now;
        bit dbad;
        halt_now = 1'b0;
        if (reset) begin
            if (m_phase == 0) model_preload();
            m_phase  = 0;
            m_exit   = '0;
            m_cycles = '0;
            m_err    = 1'b0;
            m_erra   = '0;
        end else if (m_phase == 0) begin
            model_preload();
            if (cpu_active) m_phase = 1;
        end else if (m_phase == 1) begin
            if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
            dbad = data_bad(data_address, data_read, data_write);
            if (!m_err && (dbad || fetch_bad(instr_address))) begin
                m_err  = 1'b1;
                m_erra = dbad ? data_address : instr_address;
            end
            if (data_write && !data_read) begin
                if (region(data_address) == REG_RAM)
                    m_ram[widx(data_address, RAM_BASE)] = data_writedata;
                else if (region(data_address) == REG_MMIO && data_address - MMIO_BASE == 32'd4) begin
                    m_exit   = data_writedata;
                    halt_now = 1'b1;
                end
            end
            if (halt_now || !cpu_active) m_phase = 2;
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("instr_readdata", instr_readdata, exp_fetch(instr_address));
            check("data_readdata", data_readdata, exp_load(data_address, data_read, data_write));
            check("done", 32'(done), 32'(m_phase == 2));
            check("exit_code", exit_code, m_exit);
            check("cycle_count", cycle_count, m_cycles);
            check("access_error", 32'(access_error), 32'(m_err));
            check("err_address", err_address, m_erra);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_data_addr(input bit for_read);
        int k;
        k = $urandom_range(0, 15);
        case (k)
            0, 1, 2, 3, 4, 5, 6, 7: return RAM_BASE + 32'(4 * $urandom_range(0, 15));
            8, 9:   return ROM_BASE + 32'(4 * $urandom_range(0, 15));
            10:     return MMIO_BASE;
            11:     return ($urandom_range(0, 3) == 0) ? MMIO_BASE + 32'd4 : MMIO_BASE;
            12:     return for_read ? MMIO_BASE + 32'd8 : RAM_BASE + 32'(4 * (NWORDS - 1));
            13:     return for_read ? RAM_BASE + 32'(4 * (NWORDS - 1))
                                    : RAM_BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
            14:     return ($urandom_range(0, 1) == 0) ? RAM_BASE + 32'(4 * NWORDS) : MMIO_BASE + 32'd12;
            default: return 32'h2000_0000 + 32'(4 * $urandom_range(0, 255));
        endcase
    endfunction

    logic [31:0] ram0_init;

    initial begin
        reset          = 1'b1;
        instr_address  = 32'h0;
        data_address   = 32'h0;
        data_read      = 1'b0;
        data_write     = 1'b0;
        data_writedata = 32'h0;
        cpu_active     = 1'b0;
        load_en        = 1'b0;
        load_addr      = 32'h0;
        load_data      = 32'h0;

        repeat (2) tick();
        chk_en = 1'b1;

        // Preload the whole ROM while reset is held, then the RAM while idle.
        for (int i = 0; i < NWORDS; i++) begin
            load_en   = 1'b1;
            load_addr = ROM_BASE + 32'(4 * i);
            load_data = (i == 0) ? 32'h2402_0005 : $urandom;
            tick();
        end
        reset = 1'b0;
        for (int i = 0; i < NWORDS; i++) begin
            load_en   = 1'b1;
            load_addr = RAM_BASE + 32'(4 * i);
            load_data = (i == 3) ? 32'h7 : $urandom;
            if (i == 0) ram0_init = load_data;
            tick();
        end
        load_en = 1'b0;

        // Run 1: boot fetch, store/load, EXIT after 10 run cycles.
        instr_address = ROM_BASE;
        cpu_active    = 1'b1;
        @(negedge clk);
        check("boot_fetch", instr_readdata, 32'h2402_0005);
        tick();
        data_write = 1'b1; data_address = 32'h1004; data_writedata = 32'hDEAD_BEEF;
        tick();
        data_write = 1'b0; data_read = 1'b1;
        @(negedge clk);
        check("load_after_store", data_readdata, 32'hDEAD_BEEF);
        tick();
        data_read = 1'b0;
        repeat (8) tick();
        @(negedge clk);
        check("cycles_before_exit", cycle_count, 32'd10);
        data_write = 1'b1; data_address = 32'h0F04; data_writedata = 32'h2A;
        tick();
        data_write = 1'b0;
        @(negedge clk);
        check("exit_done", 32'(done), 32'd1);
        check("exit_code_lit", exit_code, 32'h2A);
        check("exit_cycles", cycle_count, 32'd11);
        repeat (3) tick();
        @(negedge clk);
        check("frozen_cycles", cycle_count, 32'd11);

        // Run 2: misaligned store then unmapped load; first error address sticks.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        data_write = 1'b1; data_address = 32'h1002; data_writedata = 32'h1111_1111;
        tick();
        data_write = 1'b0; data_read = 1'b1; data_address = 32'h2000_0000;
        @(negedge clk);
        check("err_flag", 32'(access_error), 32'd1);
        check("err_addr_first", err_address, 32'h1002);
        check("unmapped_load", data_readdata, 32'h0);
        tick();
        data_address = 32'h1004;
        @(negedge clk);
        check("err_addr_kept", err_address, 32'h1002);
        check("ram_1004_kept", data_readdata, 32'hDEAD_BEEF);
        tick();
        data_address = 32'h1000;
        @(negedge clk);
        check("ram_1000_kept", data_readdata, ram0_init);
        tick();
        data_read  = 1'b0;
        cpu_active = 1'b0;
        tick();

        // Run 3: core drops cpu_active with no EXIT store.
        reset = 1'b1;
        tick();
        reset = 1'b0; cpu_active = 1'b1;
        tick();
        repeat (3) tick();
        cpu_active = 1'b0;
        tick();
        data_read = 1'b1; data_address = 32'h0F08;
        @(negedge clk);
        check("halt_done", 32'(done), 32'd1);
        check("halt_exit_zero", exit_code, 32'h0);
        check("status_word", data_readdata, 32'h1);
        tick();
        data_read = 1'b0;

        // Run 4: reset mid-run with a store in flight; preloaded RAM survives.
        reset = 1'b1;
        tick();
        reset = 1'b0; cpu_active = 1'b1;
        tick();
        repeat (2) tick();
        reset = 1'b1; data_write = 1'b1; data_address = 32'h100C; data_writedata = 32'h99;
        tick();
        reset = 1'b0; data_write = 1'b0;
        @(negedge clk);
        check("rst_done", 32'(done), 32'd0);
        check("rst_exit", exit_code, 32'h0);
        check("rst_cycles", cycle_count, 32'h0);
        check("rst_err", 32'(access_error), 32'd0);
        check("rst_erra", err_address, 32'h0);
        tick();
        data_read = 1'b1; data_address = 32'h100C;
        @(negedge clk);
        check("ram3_survives", data_readdata, 32'h7);
        tick();
        data_read = 1'b0;

        // Randomized phase against the model.
        for (int c = 0; c < 5000; c++) begin
            int  op;
            int  fk;
            reset = (m_phase == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0);
            cpu_active = (m_phase == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 63) != 0);
            fk = $urandom_range(0, 9);
            if (fk < 7)       instr_address = ROM_BASE + 32'(4 * $urandom_range(0, 15));
            else if (fk == 7) instr_address = 32'h0;
            else if (fk == 8) instr_address = RAM_BASE;
            else              instr_address = $urandom & 32'hFFFF_FFFC;
            op = $urandom_range(0, 9);
            data_read      = (op >= 4 && op <= 6) || op == 9;
            data_write     = (op >= 7);
            data_address   = rand_data_addr(data_read);
            data_writedata = $urandom;
            load_en        = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 2))
                0:       load_addr = RAM_BASE + 32'(4 * $urandom_range(0, 15));
                1:       load_addr = ROM_BASE + 32'(4 * $urandom_range(0, 15));
                default: load_addr = 32'h3000_0000 + 32'(4 * $urandom_range(0, 15));
            endcase
            load_data = $urandom;
            tick();
        end

        data_read  = 1'b0;
        data_write = 1'b0;
        load_en    = 1'b0;
        tick();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
